// File: rtl/core101_pkg.sv
// Shared fetch-path types: word width, fetch FSM states, queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core101_pkg;

  localparam int XLEN = 32;

  // Sequential fetch stride in bytes
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  // IDLE: no request; WAIT: request out, data kept; DROP: request out, data discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

  // Instruction fetches are word aligned; the low address bits carry no meaning
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and occupancy outputs.
// Latency: a push is visible at head on the cycle after the push edge.
// Backpressure: caller must not push when full; pop on empty is ignored; flush wins over push/pop.
module fetch_fifo import core101_pkg::*; #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_dat,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  fetch_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry storage needs no reset: head is only consumed when the queue is non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  // The issuing side reserves space before requesting, so a push on full is a design bug
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full));

endmodule

// File: rtl/ifu_fetch_queue.sv
// Sequential instruction fetcher: issues word reads, queues returned words with PCs, serves head to decode.
// Latency: first request on the edge after reset release; returned word at head one edge after mem_valid_in.
// Backpressure: a new read issues only with queue room reserved; halt stops issue, redirect flushes and restarts.
module ifu_fetch_queue #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic            halt_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_addr_in,
  output logic [XLEN-1:0] mem_addr_out,
  output logic            mem_read_out,
  input  logic            mem_valid_in,
  input  logic [XLEN-1:0] mem_data_in,
  output logic [XLEN-1:0] ir_data_out,
  output logic [XLEN-1:0] pc_out,
  output logic            ir_valid_out,
  input  logic            ir_ready_in
);
  import core101_pkg::*;

  localparam int               CNT_W    = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(QUEUE_DEPTH - 1);

  fetch_state_t     state_q;
  logic [XLEN-1:0]  fetch_pc_q;
  logic [XLEN-1:0]  req_pc_q;
  logic             mem_read_q;

  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic             q_push;
  logic             q_pop;
  fetch_entry_t     q_push_dat;
  fetch_entry_t     q_head;

  logic             issue_ok;
  logic             chain_ok;
  logic [XLEN-1:0]  redirect_pc;

  // Room is judged on the registered occupancy: a pop in this cycle does not free a slot yet
  assign issue_ok    = !halt_in && !redirect_in && !q_full;
  // Back-to-back needs room for one more after the word landing this cycle
  assign chain_ok    = !halt_in && !redirect_in && (q_count < DEPTH_M1);
  assign redirect_pc = align_word(redirect_addr_in);

  assign q_push      = (state_q == ST_WAIT) && mem_valid_in && !redirect_in;
  assign q_pop       = ir_valid_out && ir_ready_in && !redirect_in;
  assign q_push_dat  = '{pc: req_pc_q, ins: mem_data_in};

  assign mem_addr_out = req_pc_q;
  assign mem_read_out = mem_read_q;
  assign ir_valid_out = !q_empty;
  assign ir_data_out  = q_empty ? '0 : q_head.ins;
  assign pc_out       = q_empty ? '0 : q_head.pc;

  fetch_fifo #(
    .DEPTH    (QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clock_in),
    .rst_n    (reset_in),
    .flush    (redirect_in),
    .push     (q_push),
    .push_dat (q_push_dat),
    .pop      (q_pop),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Fetch FSM: request issue, completion, and redirect handling with a registered read strobe
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_ADDR;
      req_pc_q   <= RESET_ADDR;
      mem_read_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_in) begin
            fetch_pc_q <= redirect_pc;
          end else if (issue_ok) begin
            state_q    <= ST_WAIT;
            req_pc_q   <= fetch_pc_q;
            mem_read_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (redirect_in) begin
            // The bus request cannot be withdrawn; let it finish and throw the word away
            fetch_pc_q <= redirect_pc;
            if (mem_valid_in) begin
              state_q    <= ST_IDLE;
              mem_read_q <= 1'b0;
            end else begin
              state_q    <= ST_DROP;
            end
          end else if (mem_valid_in) begin
            fetch_pc_q <= req_pc_q + PC_INC;
            if (chain_ok) begin
              req_pc_q <= req_pc_q + PC_INC;
            end else begin
              state_q    <= ST_IDLE;
              mem_read_q <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (redirect_in) fetch_pc_q <= redirect_pc;
          if (mem_valid_in) begin
            state_q    <= ST_IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // The memory side relies on the address staying put until it answers
  a_addr_hold: assert property (@(posedge clock_in) disable iff (!reset_in)
    (mem_read_out && !mem_valid_in) |=> $stable(mem_addr_out));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

  localparam int DEPTH = 2;

  logic        clock_in;
  logic        reset_in;
  logic        halt_in;
  logic        redirect_in;
  logic [31:0] redirect_addr_in;
  logic [31:0] mem_addr_out;
  logic        mem_read_out;
  logic        mem_valid_in;
  logic [31:0] mem_data_in;
  logic [31:0] ir_data_out;
  logic [31:0] pc_out;
  logic        ir_valid_out;
  logic        ir_ready_in;

  int total = 0;
  int bad   = 0;

  ifu_fetch_queue #(
    .XLEN             (32),
    .RESET_ADDR       (32'h0000_0000),
    .QUEUE_DEPTH      (DEPTH)
  ) dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .halt_in          (halt_in),
    .redirect_in      (redirect_in),
    .redirect_addr_in (redirect_addr_in),
    .mem_addr_out     (mem_addr_out),
    .mem_read_out     (mem_read_out),
    .mem_valid_in     (mem_valid_in),
    .mem_data_in      (mem_data_in),
    .ir_data_out      (ir_data_out),
    .pc_out           (pc_out),
    .ir_valid_out     (ir_valid_out),
    .ir_ready_in      (ir_ready_in)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  typedef struct packed {
    logic        rst;
    logic        halt;
    logic        redir;
    logic [31:0] raddr;
    logic        mvld;
    logic [31:0] mdat;
    logic        rdy;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_ivld;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vec [NVEC];

  function automatic vec_t mk(input logic rst, input logic halt, input logic redir,
                              input logic [31:0] raddr, input logic mvld, input logic [31:0] mdat,
                              input logic rdy, input logic e_read, input logic [31:0] e_addr,
                              input logic e_ivld, input logic [31:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v = '{rst, halt, redir, raddr, mvld, mdat, rdy, e_read, e_addr, e_ivld, e_pc, e_ins};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_read, input logic [31:0] e_addr,
                          input logic e_ivld, input logic [31:0] e_pc, input logic [31:0] e_ins);
    chk({tag, " mem_read"}, {31'd0, mem_read_out}, {31'd0, e_read});
    chk({tag, " mem_addr"}, mem_addr_out, e_addr);
    chk({tag, " ir_valid"}, {31'd0, ir_valid_out}, {31'd0, e_ivld});
    chk({tag, " pc"},       pc_out, e_pc);
    chk({tag, " ir_data"},  ir_data_out, e_ins);
  endtask

  // Behavioural reference: outstanding-request flags, next PC, and a queue of {pc, ins}
  logic        m_busy;
  logic        m_keep;
  logic [31:0] m_req;
  logic [31:0] m_fetch;
  logic [63:0] mq [$];

  task automatic model_reset();
    m_busy  = 1'b0;
    m_keep  = 1'b0;
    m_req   = 32'h0;
    m_fetch = 32'h0;
    mq.delete();
  endtask

  task automatic model_step(input logic h, input logic r, input logic [31:0] ra,
                            input logic mv, input logic [31:0] md, input logic rdy);
    int occ;
    occ = mq.size();
    if (r) begin
      mq.delete();
      m_fetch = {ra[31:2], 2'b00};
      if (m_busy && mv) m_busy = 1'b0;
      else if (m_busy)  m_keep = 1'b0;
    end else begin
      if (occ != 0 && rdy) void'(mq.pop_front());
      if (m_busy && mv) begin
        if (m_keep) begin
          mq.push_back({m_req, md});
          m_fetch = m_req + 32'd4;
          if (!h && (occ + 1) < DEPTH) m_req = m_req + 32'd4;
          else                         m_busy = 1'b0;
        end else begin
          m_busy = 1'b0;
        end
      end else if (!m_busy && !h && occ < DEPTH) begin
        m_busy = 1'b1;
        m_keep = 1'b1;
        m_req  = m_fetch;
      end
    end
  endtask

  initial begin
    logic [63:0] hd;
    logic        r_h, r_r, r_mv, r_rdy;
    logic [31:0] r_ra, r_md;

    // Directed vectors: inputs held for one edge, outputs expected after that edge
    //            rst  halt redir raddr         mvld mdat          rdy  read addr          ivld pc            ins
    vec[0]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b1,32'h0,        1'b0,32'h0,        32'h0);
    vec[1]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00410333, 1'b1,1'b1,32'h4,        1'b1,32'h0,        32'h00410333);
    vec[2]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00000013, 1'b1,1'b0,32'h4,        1'b1,32'h4,        32'h00000013);
    vec[3]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h0);
    vec[4]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h11111111, 1'b0,1'b1,32'h0,        1'b0,32'h0,        32'h0);
    vec[5]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hAAAA0001, 1'b0,1'b1,32'h4,        1'b1,32'h0,        32'hAAAA0001);
    vec[6]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBBBB0002, 1'b0,1'b0,32'h4,        1'b1,32'h0,        32'hAAAA0001);
    vec[7]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hCCCC0003, 1'b0,1'b0,32'h4,        1'b1,32'h0,        32'hAAAA0001);
    vec[8]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h4,        1'b1,32'h4,        32'hBBBB0002);
    vec[9]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h8,        1'b1,32'h4,        32'hBBBB0002);
    vec[10] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h8,        1'b1,32'h4,        32'hBBBB0002);
    vec[11] = mk(1'b0,1'b0,1'b1,32'h103,      1'b0,32'h0,        1'b0,1'b1,32'h8,        1'b0,32'h0,        32'h0);
    vec[12] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h8,        1'b0,32'h0,        32'h0);
    vec[13] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h8,        1'b0,32'h0,        32'h0);
    vec[14] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hDDDD0004, 1'b0,1'b0,32'h8,        1'b0,32'h0,        32'h0);
    vec[15] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h100,      1'b0,32'h0,        32'h0);
    vec[16] = mk(1'b0,1'b0,1'b1,32'h202,      1'b1,32'hEEEE0005, 1'b0,1'b0,32'h100,      1'b0,32'h0,        32'h0);
    vec[17] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h200,      1'b0,32'h0,        32'h0);
    vec[18] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h200,      1'b0,32'h0,        32'h0);
    vec[19] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,32'hFFFF0006, 1'b0,1'b0,32'h200,      1'b1,32'h200,      32'hFFFF0006);
    vec[20] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h200,      1'b0,32'h0,        32'h0);
    vec[21] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h200,      1'b0,32'h0,        32'h0);
    vec[22] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h204,      1'b0,32'h0,        32'h0);
    vec[23] = mk(1'b0,1'b0,1'b1,32'hFFFFFFFF, 1'b0,32'h0,        1'b0,1'b1,32'h204,      1'b0,32'h0,        32'h0);
    vec[24] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0BAD0007, 1'b0,1'b0,32'h204,      1'b0,32'h0,        32'h0);
    vec[25] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hFFFFFFFC, 1'b0,32'h0,        32'h0);
    vec[26] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h12345678, 1'b0,1'b1,32'h0,        1'b1,32'hFFFFFFFC, 32'h12345678);
    vec[27] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b1,32'h0,        1'b0,32'h0,        32'h0);

    reset_in = 1'b0; halt_in = 1'b0; redirect_in = 1'b0; redirect_addr_in = '0;
    mem_valid_in = 1'b0; mem_data_in = '0; ir_ready_in = 1'b0;
    repeat (2) @(negedge clock_in);
    chk_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      reset_in         = ~vec[i].rst;
      halt_in          = vec[i].halt;
      redirect_in      = vec[i].redir;
      redirect_addr_in = vec[i].raddr;
      mem_valid_in     = vec[i].mvld;
      mem_data_in      = vec[i].mdat;
      ir_ready_in      = vec[i].rdy;
      @(negedge clock_in);
      chk_outs($sformatf("vec%0d", i), vec[i].e_read, vec[i].e_addr,
               vec[i].e_ivld, vec[i].e_pc, vec[i].e_ins);
    end

    // Async reset while a request to 0x0 is outstanding: outputs clear without a clock edge
    mem_valid_in = 1'b0; ir_ready_in = 1'b0;
    @(posedge clock_in);
    #3;
    reset_in = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // A stray valid with no request is ignored after reset release
    @(negedge clock_in);
    mem_valid_in = 1'b1; mem_data_in = 32'h5555AAAA;
    reset_in = 1'b1;
    @(negedge clock_in);
    chk_outs("post_rst_issue", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clock_in);
    chk_outs("post_rst_push", 1'b1, 32'h4, 1'b1, 32'h0, 32'h5555AAAA);

    // Randomized phase against the reference model
    reset_in = 1'b0; mem_valid_in = 1'b0; halt_in = 1'b0; redirect_in = 1'b0; ir_ready_in = 1'b0;
    @(negedge clock_in);
    reset_in = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      hd = (mq.size() != 0) ? mq[0] : 64'h0;
      chk_outs($sformatf("rnd%0d", c), m_busy, m_req, (mq.size() != 0), hd[63:32], hd[31:0]);
      r_h   = ($urandom_range(0, 99) < 15);
      r_r   = ($urandom_range(0, 99) < 6);
      r_ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      r_mv  = ($urandom_range(0, 99) < 50);
      r_md  = $urandom;
      r_rdy = ($urandom_range(0, 99) < 60);
      halt_in = r_h; redirect_in = r_r; redirect_addr_in = r_ra;
      mem_valid_in = r_mv; mem_data_in = r_md; ir_ready_in = r_rdy;
      model_step(r_h, r_r, r_ra, r_mv, r_md, r_rdy);
      @(negedge clock_in);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
